// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-side queue.
// The ring entry carries the fetch PC, the returned instruction and a filled flag.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_RESET = 32'h0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ring.sv
// In-order ring of fetch entries with three pointers: head (oldest), fill (oldest
// unfilled) and tail (next allocation). Pointers carry one extra wrap bit.
module fetch_ring
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            alloc_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_data_i,
  input  logic            pop_i,
  output fetch_entry_t    head_o,
  output logic [PTR_W:0]  occ_o,
  output logic [PTR_W:0]  unf_o
);

  localparam logic [PTR_W:0] PTR_ONE = 1;
  localparam logic [PTR_W:0] PTR_DEPTH = DEPTH;

  fetch_entry_t entry_q [DEPTH];
  fetch_entry_t entry_d [DEPTH];

  logic [PTR_W:0]   head_q, head_d;
  logic [PTR_W:0]   fill_q, fill_d;
  logic [PTR_W:0]   tail_q, tail_d;
  logic [PTR_W-1:0] head_idx, fill_idx, tail_idx;

  assign head_idx = head_q[PTR_W-1:0];
  assign fill_idx = fill_q[PTR_W-1:0];
  assign tail_idx = tail_q[PTR_W-1:0];

  assign occ_o  = tail_q - head_q;
  assign unf_o  = tail_q - fill_q;
  assign head_o = entry_q[head_idx];

  // Allocation, fill and pop never target the same slot: tail is ahead of fill
  // whenever a fill happens, and pop needs a filled head while fill is unfilled.
  always_comb begin
    entry_d = entry_q;
    head_d  = head_q;
    fill_d  = fill_q;
    tail_d  = tail_q;
    if (clear_i) begin
      head_d = '0;
      fill_d = '0;
      tail_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_d[i].filled = 1'b0;
      end
    end else begin
      if (alloc_i) begin
        entry_d[tail_idx].pc     = alloc_pc_i;
        entry_d[tail_idx].filled = 1'b0;
        tail_d                   = tail_q + PTR_ONE;
      end
      if (fill_i) begin
        entry_d[fill_idx].data   = fill_data_i;
        entry_d[fill_idx].filled = 1'b1;
        fill_d                   = fill_q + PTR_ONE;
      end
      if (pop_i) begin
        entry_d[head_idx].filled = 1'b0;
        head_d                   = head_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i].pc     <= PC_RESET;
        entry_q[i].data   <= '0;
        entry_q[i].filled <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      fill_q  <= fill_d;
      tail_q  <= tail_d;
      entry_q <= entry_d;
    end
  end

  a_no_alloc_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    (alloc_i && !clear_i) |-> (occ_o < PTR_DEPTH));
  a_no_fill_when_none: assert property (@(posedge clk) disable iff (!rst_n)
    (fill_i && !clear_i) |-> (unf_o != '0));
  a_no_pop_unfilled: assert property (@(posedge clk) disable iff (!rst_n)
    (pop_i && !clear_i) |-> head_o.filled);

endmodule

// File: rtl/fetch_queue.sv
// Fetch buffer between the PC stage and decode: issues one imem request per PC,
// tracks in-order responses in a ring, and drops stale responses after a redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] PC_F,
  input  logic            flush_F,
  output logic            stall_F,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            valid_D,
  output logic [XLEN-1:0] instr_D,
  output logic [XLEN-1:0] PC_D,
  input  logic            ready_D
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_W = DEPTH;
  localparam logic [PTR_W+1:0] ONE_W   = 1;
  localparam logic [PTR_W:0]   ONE_P   = 1;

  fetch_entry_t     head_entry;
  logic [PTR_W:0]   occ, unf;
  logic [PTR_W:0]   discard_cnt_q, discard_cnt_d;
  logic [PTR_W+1:0] credit_used;
  logic [PTR_W+1:0] owed;
  logic             accept, fill, pop;

  fetch_ring #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_ring (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (flush_F),
    .alloc_i    (accept),
    .alloc_pc_i (PC_F),
    .fill_i     (fill),
    .fill_data_i(imem_resp_data),
    .pop_i      (pop),
    .head_o     (head_entry),
    .occ_o      (occ),
    .unf_o      (unf)
  );

  assign imem_req_addr = PC_F;
  assign valid_D       = head_entry.filled;
  assign instr_D       = head_entry.data;
  assign PC_D          = head_entry.pc;

  // Stale fetches still owe responses, so they consume ring credit until dropped.
  always_comb begin
    credit_used    = {1'b0, occ} + {1'b0, discard_cnt_q};
    imem_req_valid = !flush_F && (credit_used < DEPTH_W);
    accept         = imem_req_valid && imem_req_ready;
    stall_F        = !flush_F && !accept;
    fill           = imem_resp_valid && !flush_F && (discard_cnt_q == '0) && (unf != '0);
    pop            = valid_D && ready_D && !flush_F;
  end

  // On flush every response still owed becomes a discard, minus the one landing now.
  always_comb begin
    owed          = {1'b0, discard_cnt_q} + {1'b0, unf};
    discard_cnt_d = discard_cnt_q;
    if (flush_F) begin
      if (imem_resp_valid && (owed != '0)) begin
        owed = owed - ONE_W;
      end
      discard_cnt_d = owed[PTR_W:0];
    end else if (imem_resp_valid && (discard_cnt_q != '0)) begin
      discard_cnt_d = discard_cnt_q - ONE_P;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      discard_cnt_q <= '0;
    end else begin
      discard_cnt_q <= discard_cnt_d;
    end
  end

  a_resp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> ((discard_cnt_q != '0) || (unf != '0)));
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    credit_used <= DEPTH_W);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: the bench plays the PC stage and a fixed-latency
// in-order instruction memory returning 0x1000 + address.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC_F;
  logic        flush_F;
  logic        stall_F;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        valid_D;
  logic [31:0] instr_D;
  logic [31:0] PC_D;
  logic        ready_D;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PC_F           (PC_F),
    .flush_F        (flush_F),
    .stall_F        (stall_F),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .valid_D        (valid_D),
    .instr_D        (instr_D),
    .PC_D           (PC_D),
    .ready_D        (ready_D)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          lat = 1;
  logic        mv [3];
  logic [31:0] ma [3];
  logic [31:0] flush_tgt;
  logic        s_rst, s_acc, s_stall, s_flush;
  logic [31:0] s_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, obs);
    end
  endtask

  // One clock: sample handshakes at negedge, then advance memory and PC models.
  task automatic tick();
    @(negedge clk);
    s_rst   = rst_n;
    s_acc   = imem_req_valid && imem_req_ready;
    s_addr  = imem_req_addr;
    s_stall = stall_F;
    s_flush = flush_F;
    @(posedge clk);
    #1;
    if (!s_rst) begin
      for (int i = 0; i < 3; i++) begin
        mv[i] = 1'b0;
        ma[i] = 32'h0;
      end
      PC_F = 32'h0;
    end else begin
      for (int i = 2; i > 0; i--) begin
        mv[i] = mv[i-1];
        ma[i] = ma[i-1];
      end
      mv[0] = s_acc;
      ma[0] = s_addr;
      if (s_flush) PC_F = flush_tgt;
      else if (!s_stall) PC_F = PC_F + 32'h1;
    end
    imem_resp_valid = mv[lat-1];
    imem_resp_data  = 32'h1000 + ma[lat-1];
  endtask

  task automatic do_reset(input int latency);
    rst_n   = 1'b0;
    flush_F = 1'b0;
    lat     = latency;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; PC_F = 32'h0; flush_F = 1'b0; imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0; ready_D = 1'b1; flush_tgt = 32'h0;
    for (int i = 0; i < 3; i++) begin
      mv[i] = 1'b0;
      ma[i] = 32'h0;
    end

    // Streaming with a 1-cycle memory
    do_reset(1);
    check("rst valid_D", 32'(valid_D), 32'h0);
    check("rst req_valid", 32'(imem_req_valid), 32'h1);
    check("rst discard", 32'(dut.discard_cnt_q), 32'h0);
    check("a0 req_addr", imem_req_addr, 32'h0);
    tick();
    check("a1 valid_D", 32'(valid_D), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("seq%0d valid_D", k), 32'(valid_D), 32'h1);
      check($sformatf("seq%0d PC_D", k), PC_D, 32'(k));
      check($sformatf("seq%0d instr_D", k), instr_D, 32'h1000 + 32'(k));
    end

    // Fill to DEPTH with decode blocked, then release
    do_reset(1);
    ready_D = 1'b0;
    #1;
    repeat (5) tick();
    check("full req_valid", 32'(imem_req_valid), 32'h0);
    check("full stall_F", 32'(stall_F), 32'h1);
    check("full req_addr", imem_req_addr, 32'h4);
    check("full PC_D", PC_D, 32'h0);
    ready_D = 1'b1;
    #1;
    check("pop-cycle stall_F", 32'(stall_F), 32'h1);
    check("pop-cycle req_valid", 32'(imem_req_valid), 32'h0);
    tick();
    check("after-pop req_valid", 32'(imem_req_valid), 32'h1);
    check("after-pop req_addr", imem_req_addr, 32'h4);
    check("after-pop stall_F", 32'(stall_F), 32'h0);
    check("after-pop PC_D", PC_D, 32'h1);

    // Flush with resp and pop in the same cycle, 3-cycle memory
    do_reset(3);
    repeat (6) tick();
    check("pre-flush req_addr", imem_req_addr, 32'h5);
    check("pre-flush PC_D", PC_D, 32'h2);
    flush_tgt = 32'h40;
    flush_F   = 1'b1;
    #1;
    check("flush stall_F", 32'(stall_F), 32'h0);
    check("flush req_valid", 32'(imem_req_valid), 32'h0);
    tick();
    flush_F = 1'b0;
    #1;
    check("post-flush valid_D", 32'(valid_D), 32'h0);
    check("post-flush discard", 32'(dut.discard_cnt_q), 32'h1);
    check("post-flush req_addr", imem_req_addr, 32'h40);
    tick();
    check("drop-cycle valid_D", 32'(valid_D), 32'h0);
    tick();
    check("dropped discard", 32'(dut.discard_cnt_q), 32'h0);
    check("dropped valid_D", 32'(valid_D), 32'h0);
    tick();
    check("target-resp valid_D", 32'(valid_D), 32'h0);
    tick();
    check("target valid_D", 32'(valid_D), 32'h1);
    check("target PC_D", PC_D, 32'h40);
    check("target instr_D", instr_D, 32'h1040);

    // Back-to-back flushes accumulate discards
    do_reset(3);
    repeat (2) tick();
    flush_tgt = 32'h80;
    flush_F   = 1'b1;
    #1;
    tick();
    check("b2b discard after 1st", 32'(dut.discard_cnt_q), 32'h2);
    tick();
    flush_F = 1'b0;
    #1;
    check("b2b discard after 2nd", 32'(dut.discard_cnt_q), 32'h1);
    check("b2b req_addr", imem_req_addr, 32'h80);
    tick();
    check("b2b discard drained", 32'(dut.discard_cnt_q), 32'h0);
    repeat (2) tick();
    check("b2b wait valid_D", 32'(valid_D), 32'h0);
    tick();
    check("b2b valid_D", 32'(valid_D), 32'h1);
    check("b2b PC_D", PC_D, 32'h80);
    check("b2b instr_D", instr_D, 32'h1080);

    // Memory not ready for 5 cycles
    do_reset(1);
    imem_req_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("nrdy%0d stall_F", k), 32'(stall_F), 32'h1);
      check($sformatf("nrdy%0d req_addr", k), imem_req_addr, 32'h0);
      check($sformatf("nrdy%0d occ", k), 32'(dut.occ), 32'h0);
      tick();
    end
    check("nrdy req_valid", 32'(imem_req_valid), 32'h1);
    imem_req_ready = 1'b1;
    #1;
    check("rdy stall_F", 32'(stall_F), 32'h0);
    repeat (2) tick();
    check("rdy valid_D", 32'(valid_D), 32'h1);
    check("rdy PC_D", PC_D, 32'h0);

    // Reset mid-operation with three filled entries
    do_reset(1);
    ready_D = 1'b0;
    #1;
    repeat (4) tick();
    check("pre-rst valid_D", 32'(valid_D), 32'h1);
    check("pre-rst occ", 32'(dut.occ), 32'h4);
    do_reset(1);
    check("mid-rst valid_D", 32'(valid_D), 32'h0);
    check("mid-rst req_valid", 32'(imem_req_valid), 32'h1);
    check("mid-rst discard", 32'(dut.discard_cnt_q), 32'h0);
    check("mid-rst req_addr", imem_req_addr, 32'h0);
    ready_D = 1'b1;
    repeat (2) tick();
    check("resume valid_D", 32'(valid_D), 32'h1);
    check("resume PC_D", PC_D, 32'h0);
    check("resume instr_D", instr_D, 32'h1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
